// File: rtl/spi_fb_loader.sv
// spi_fb_loader: SPI mode-0 slave that streams pixels into the LCD framebuffer.
// The SPI pins are oversampled in clk_50mhz. Command bytes either set the write address
// or start a pixel stream that produces one framebuffer write per complete pixel.
// Optional feature macro: SPI_FB_RGB565_EN selects a 2-byte RGB565 pixel format instead of
// the default 3-byte R,G,B format (6 significant bits per byte).
module spi_fb_loader #(
    parameter int ADDR_W      = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_50mhz,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [17:0]       fb_wdata,
    output logic              frame_done,
    output logic              cmd_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ADDR_HI = 3'd2,
        ADDR_LO = 3'd3,
        PIX     = 3'd4,
        DISCARD = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
    logic                   sck_s, csn_s, mosi_s, sck_rise_s;
    logic                   sck_prev_q;
    logic [7:0]             shift_q;
    logic [2:0]             bit_cnt_q;
    logic                   byte_valid_q;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [1:0]             pix_cnt_q, pix_cnt_d;
    logic [5:0]             r_q, r_d, g_q, g_d;
    logic                   cmd_err_q, cmd_err_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      fb_addr_q, fb_addr_d;
    logic [17:0]            wdata_q, wdata_d;
    logic                   frame_done_q, frame_done_d;

    // Equal-depth synchronizers so SCK, CS_N and MOSI keep their relative timing.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= {SYNC_STAGES{1'b0}};
            csn_sync_q  <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign csn_s      = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_prev_q;

    // Deserializer: shift MSB first on SCK rises while selected; flag a byte one cycle after the 8th bit.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            sck_prev_q   <= 1'b0;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_valid_q <= 1'b0;
        end else begin
            sck_prev_q   <= sck_s;
            byte_valid_q <= 1'b0;
            if (csn_s || (state_q == IDLE)) begin
                // Deselect (or idle) drops any partial byte; a coincident SCK rise is lost.
                bit_cnt_q <= 3'd0;
            end else if (sck_rise_s) begin
                shift_q <= {shift_q[6:0], mosi_s};
                if (bit_cnt_q == 3'd7) begin
                    bit_cnt_q    <= 3'd0;
                    byte_valid_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
            end
        end
    end

    // Command FSM next state plus address, pixel assembly and write-port next values.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pix_cnt_d    = pix_cnt_q;
        r_d          = r_q;
        g_d          = g_q;
        cmd_err_d    = cmd_err_q;
        we_d         = 1'b0;
        fb_addr_d    = fb_addr_q;
        wdata_d      = wdata_q;
        frame_done_d = 1'b0;
        if (csn_s) begin
            state_d   = IDLE;
            pix_cnt_d = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = CMD;
                    pix_cnt_d = 2'd0;
                end
                CMD: begin
                    if (byte_valid_q) begin
                        if (shift_q == 8'h01) begin
                            state_d   = ADDR_HI;
                            cmd_err_d = 1'b0;
                        end else if (shift_q == 8'h02) begin
                            state_d   = PIX;
                            pix_cnt_d = 2'd0;
                            cmd_err_d = 1'b0;
                        end else begin
                            state_d   = DISCARD;
                            cmd_err_d = 1'b1;
                        end
                    end else begin
                        state_d = CMD;
                    end
                end
                ADDR_HI: begin
                    if (byte_valid_q) begin
                        addr_d  = {shift_q[ADDR_W-9:0], addr_q[7:0]};
                        state_d = ADDR_LO;
                    end else begin
                        state_d = ADDR_HI;
                    end
                end
                ADDR_LO: begin
                    if (byte_valid_q) begin
                        addr_d[7:0] = shift_q;
                        state_d     = DISCARD;
                    end else begin
                        state_d = ADDR_LO;
                    end
                end
                PIX: begin
                    if (byte_valid_q) begin
`ifdef SPI_FB_RGB565_EN
                        if (pix_cnt_q == 2'd0) begin
                            // First byte: R5 and the top three bits of G6.
                            r_d       = {shift_q[7:3], shift_q[7]};
                            g_d       = {shift_q[2:0], 3'b000};
                            pix_cnt_d = 2'd1;
                        end else begin
                            we_d         = 1'b1;
                            fb_addr_d    = addr_q;
                            wdata_d      = {shift_q[4:0], shift_q[4], g_q[5:3], shift_q[7:5], r_q};
                            frame_done_d = (addr_q == {ADDR_W{1'b1}});
                            addr_d       = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                            pix_cnt_d    = 2'd0;
                        end
`else
                        case (pix_cnt_q)
                            2'd0: begin
                                r_d       = shift_q[5:0];
                                pix_cnt_d = 2'd1;
                            end
                            2'd1: begin
                                g_d       = shift_q[5:0];
                                pix_cnt_d = 2'd2;
                            end
                            default: begin
                                we_d         = 1'b1;
                                fb_addr_d    = addr_q;
                                wdata_d      = {shift_q[5:0], g_q, r_q};
                                frame_done_d = (addr_q == {ADDR_W{1'b1}});
                                addr_d       = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                                pix_cnt_d    = 2'd0;
                            end
                        endcase
`endif
                    end else begin
                        state_d = PIX;
                    end
                end
                DISCARD: begin
                    state_d = DISCARD;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, address, pixel holding registers and the registered write port.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= {ADDR_W{1'b0}};
            pix_cnt_q    <= 2'd0;
            r_q          <= 6'd0;
            g_q          <= 6'd0;
            cmd_err_q    <= 1'b0;
            we_q         <= 1'b0;
            fb_addr_q    <= {ADDR_W{1'b0}};
            wdata_q      <= 18'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pix_cnt_q    <= pix_cnt_d;
            r_q          <= r_d;
            g_q          <= g_d;
            cmd_err_q    <= cmd_err_d;
            we_q         <= we_d;
            fb_addr_q    <= fb_addr_d;
            wdata_q      <= wdata_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fb_we      = we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_wdata   = wdata_q;
    assign frame_done = frame_done_q;
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_spi_fb_loader.sv
// Bench for spi_fb_loader (default 3-byte pixel format, ADDR_W=14).
// A transaction-level model predicts every framebuffer write; a per-cycle monitor matches
// DUT writes against that prediction, and literal expectations pin the scenarios.
module tb_spi_fb_loader;

    logic        clk_50mhz;
    logic        rst;
    logic        spi_clk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        fb_we;
    logic [13:0] fb_addr;
    logic [17:0] fb_wdata;
    logic        frame_done;
    logic        cmd_err;

    int checks   = 0;
    int failures = 0;

    spi_fb_loader #(.ADDR_W(14), .SYNC_STAGES(2)) dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .spi_clk   (spi_clk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata),
        .frame_done(frame_done),
        .cmd_err   (cmd_err)
    );

    initial clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    // ---------------- behavioural model ----------------
    // m_st: 0 = awaiting command, 1 = address high, 2 = address low, 3 = pixels, 4 = ignoring
    int m_st   = 0;
    int m_addr = 0;
    int m_cnt  = 0;
    int m_r    = 0;
    int m_g    = 0;
    bit m_err  = 1'b0;
    int exp_addr_q[$];
    int exp_data_q[$];
    bit exp_fd_q[$];

    task automatic model_byte(input int b);
        case (m_st)
            0: begin
                if (b == 1) begin m_st = 1; m_err = 1'b0; end
                else if (b == 2) begin m_st = 3; m_cnt = 0; m_err = 1'b0; end
                else begin m_st = 4; m_err = 1'b1; end
            end
            1: begin m_addr = (b % 64) * 256 + (m_addr % 256); m_st = 2; end
            2: begin m_addr = (m_addr / 256) * 256 + b; m_st = 4; end
            3: begin
                if (m_cnt == 0) begin m_r = b % 64; m_cnt = 1; end
                else if (m_cnt == 1) begin m_g = b % 64; m_cnt = 2; end
                else begin
                    exp_addr_q.push_back(m_addr);
                    exp_data_q.push_back((b % 64) * 4096 + m_g * 64 + m_r);
                    exp_fd_q.push_back(m_addr == 16383);
                    m_addr = (m_addr + 1) % 16384;
                    m_cnt  = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_cs_high();
        m_st  = 0;
        m_cnt = 0;
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_addr = 0; m_err = 1'b0;
    endtask

    // ---------------- per-cycle write monitor ----------------
    int wr_count  = 0;
    int fd_count  = 0;
    int last_addr = -1;
    int last_data = -1;
    bit last_fd   = 1'b0;
    bit prev_we   = 1'b0;

    // Compare every DUT write against the model's prediction, away from the active edge.
    always @(negedge clk_50mhz) begin
        if (!rst) begin
            if (fb_we) begin
                wr_count  = wr_count + 1;
                last_addr = int'(fb_addr);
                last_data = int'(fb_wdata);
                last_fd   = frame_done;
                if (frame_done) fd_count = fd_count + 1;
                checks = checks + 1;
                if (exp_addr_q.size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL unexpected_write actual addr=%0h data=%0h required no write", fb_addr, fb_wdata);
                end else begin
                    int ea, ed;
                    bit ef;
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    ef = exp_fd_q.pop_front();
                    if (int'(fb_addr) != ea || int'(fb_wdata) != ed || frame_done != ef) begin
                        failures = failures + 1;
                        $display("FAIL write_match actual addr=%0h data=%0h fd=%0b required addr=%0h data=%0h fd=%0b",
                                 fb_addr, fb_wdata, frame_done, ea, ed, ef);
                    end
                end
                checks = checks + 1;
                if (prev_we) begin
                    failures = failures + 1;
                    $display("FAIL we_back_to_back actual=1 required=0");
                end
            end else if (frame_done) begin
                checks   = checks + 1;
                failures = failures + 1;
                $display("FAIL frame_done_without_we actual=1 required=0");
            end
            prev_we = fb_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = b[7-i];
            #120;
            spi_clk = 1'b1;
            #120;
            spi_clk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] b);
        model_byte(int'(b));
        spi_bits(b, 8);
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        #200;
    endtask

    task automatic cs_end();
        #120;
        spi_cs_n = 1'b1;
        model_cs_high();
        #200;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst      = 1'b1;
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #55;
        chk("reset_fb_we", int'(fb_we), 0);
        chk("reset_fb_addr", int'(fb_addr), 0);
        chk("reset_fb_wdata", int'(fb_wdata), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        chk("reset_cmd_err", int'(cmd_err), 0);
        @(negedge clk_50mhz);
        rst = 1'b0;
        repeat (4) @(negedge clk_50mhz);

        // Set address 5: no write may happen.
        cs_begin(); xfer(8'h01); xfer(8'h00); xfer(8'h05); cs_end();
        chk("t1_no_write", wr_count, 0);

        // One pixel to 5, then a second pixel lands at 6.
        cs_begin(); xfer(8'h02); xfer(8'h3F); xfer(8'h00); xfer(8'h15);
        #400;
        chk("t2_count", wr_count, 1);
        chk("t2_addr", last_addr, 32'h5);
        chk("t2_data", last_data, 32'h1503F);
        xfer(8'h0A); xfer(8'h0B); xfer(8'h0C);
        #400;
        chk("t2_next_addr", last_addr, 32'h6);
        cs_end();

        // Partial pixel (R, G, half of B) is dropped; the retry writes at the same address.
        cs_begin(); xfer(8'h02); xfer(8'h11); xfer(8'h22); spi_bits(8'hA0, 4); cs_end();
        chk("t4_partial_no_write", wr_count, 2);
        cs_begin(); xfer(8'h02); xfer(8'h01); xfer(8'h02); xfer(8'h03); cs_end();
        chk("t4_count", wr_count, 3);
        chk("t4_addr", last_addr, 32'h7);
        chk("t4_data", last_data, 32'h3081);

        // Last address of the frame, then wrap to 0.
        cs_begin(); xfer(8'h01); xfer(8'h3F); xfer(8'hFF); cs_end();
        cs_begin(); xfer(8'h02);
        xfer(8'h04); xfer(8'h05); xfer(8'h06);
        xfer(8'h07); xfer(8'h08); xfer(8'h09);
        cs_end();
        chk("t3_count", wr_count, 5);
        chk("t3_frame_done_count", fd_count, 1);
        chk("t3_wrap_addr", last_addr, 32'h0);
        chk("t3_wrap_fd", int'(last_fd), 0);

        // Unknown command: sticky error, no writes, cleared by the next pixel command.
        cs_begin(); xfer(8'h7E);
        #200;
        chk("t5_err_set", int'(cmd_err), 1);
        xfer(8'h02); xfer(8'h11); xfer(8'h22); xfer(8'h33);
        cs_end();
        chk("t5_err_sticky", int'(cmd_err), 1);
        chk("t5_err_model", int'(cmd_err), int'(m_err));
        chk("t5_no_write", wr_count, 5);
        cs_begin(); xfer(8'h02);
        #200;
        chk("t5_err_clear", int'(cmd_err), 0);
        xfer(8'h01); xfer(8'h02); xfer(8'h03);
        cs_end();
        chk("t5_addr", last_addr, 32'h1);

        // Reset between G and B: outputs clear at once, pending pixel discarded.
        cs_begin(); xfer(8'h02); xfer(8'h0A); xfer(8'h0B);
        @(negedge clk_50mhz);
        rst = 1'b1;
        #1;
        chk("t6_rst_we", int'(fb_we), 0);
        chk("t6_rst_addr", int'(fb_addr), 0);
        chk("t6_rst_data", int'(fb_wdata), 0);
        chk("t6_rst_err", int'(cmd_err), 0);
        spi_cs_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk_50mhz);
        rst = 1'b0;
        repeat (10) @(negedge clk_50mhz);
        chk("t6_no_write", wr_count, 6);
        cs_begin(); xfer(8'h02); xfer(8'h0C); xfer(8'h0D); xfer(8'h0E); cs_end();
        chk("t6_addr", last_addr, 32'h0);
        chk("t6_data", last_data, 32'hE34C);

        repeat (20) @(negedge clk_50mhz);
        chk("pending_writes", exp_addr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
